// File: rtl/h264_pipe_sequencer.sv
// Stage-enable sequencer for the H.264 core-transform pipeline: load phase, walking one-hot, inter-block gap.
// Optional 16-bit completed-block counter output when H264_SEQ_BLKCNT_EN is defined.
module h264_pipe_sequencer #(
    parameter int NSTAGES  = 4,
    parameter int LOAD_LEN = 4,
    parameter int GAP      = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ENABLE,
    input  logic               STALL,
    output logic [NSTAGES-1:0] en_stage,
    output logic               busy,
    output logic               ready,
    output logic               done,
    output logic               ovf
`ifdef H264_SEQ_BLKCNT_EN
    ,
    output logic [15:0]        blk_cnt
`endif
);

    localparam int ACTIVE = (LOAD_LEN > NSTAGES) ? LOAD_LEN : NSTAGES;
    localparam int CMAX   = (ACTIVE > GAP) ? ACTIVE : GAP;
    localparam int CW     = $clog2((CMAX > 2) ? CMAX : 2);

    localparam logic [31:0] LAST_RUN = 32'(ACTIVE - 1);
    localparam logic [31:0] LAST_GAP = (GAP > 0) ? 32'(GAP - 1) : 32'd0;
    localparam logic [31:0] LOAD_U   = 32'(LOAD_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          pend, pend_nxt;
    logic          launch;
    logic [31:0]   cnt_w;

    // Comparisons are done on a zero-extended copy so LOAD_LEN may exceed the counter's range.
    assign cnt_w = 32'(cnt);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        launch    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ENABLE) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (!STALL) begin
                    if (cnt_w == LAST_RUN) begin
                        cnt_nxt = '0;
                        if (GAP > 0) begin
                            state_nxt = ST_GAP;
                        end else if (pend || ENABLE) begin
                            state_nxt = ST_RUN;
                            launch    = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_w == LAST_GAP) begin
                    cnt_nxt = '0;
                    if (pend || ENABLE) begin
                        state_nxt = ST_RUN;
                        launch    = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // A launch swallows the queued request and any same-cycle ENABLE as one request.
        pend_nxt = pend;
        if (launch)
            pend_nxt = 1'b0;
        else if (busy && ENABLE && !pend)
            pend_nxt = 1'b1;
    end

    always_comb begin
        en_stage = '0;
        busy     = (state != ST_IDLE);
        ready    = !pend;
        done     = (state == ST_RUN) && !STALL && (cnt_w == LAST_RUN);
        ovf      = busy && ENABLE && pend && !launch;
        if (state == ST_RUN && !STALL) begin
            en_stage[0] = (cnt_w < LOAD_U);
            for (int k = 1; k < NSTAGES; k++)
                en_stage[k] = (cnt_w == 32'(k));
        end
    end

`ifdef H264_SEQ_BLKCNT_EN
    always_ff @(posedge CLK) begin
        if (!RESET)
            blk_cnt <= 16'd0;
        else if (done)
            blk_cnt <= blk_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_h264_pipe_sequencer.sv
// Directed bench for h264_pipe_sequencer: default instance plus a NSTAGES=6/LOAD_LEN=2/GAP=0 instance.
// Expected per-cycle values are hand-derived tables; cycle 0 is the cycle ENABLE is first driven.
module tb_h264_pipe_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       ENABLE = 1'b0;
    logic       STALL = 1'b0;
    logic       enable_b = 1'b0;
    logic [3:0] en_a;
    logic       busy_a, ready_a, done_a, ovf_a;
    logic [5:0] en_b;
    logic       busy_b, ready_b, done_b, ovf_b;
`ifdef H264_SEQ_BLKCNT_EN
    logic [15:0] blk_a, blk_b;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    h264_pipe_sequencer dut_a (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .STALL(STALL),
        .en_stage(en_a), .busy(busy_a), .ready(ready_a), .done(done_a), .ovf(ovf_a)
`ifdef H264_SEQ_BLKCNT_EN
        , .blk_cnt(blk_a)
`endif
    );

    h264_pipe_sequencer #(.NSTAGES(6), .LOAD_LEN(2), .GAP(0)) dut_b (
        .CLK(CLK), .RESET(RESET), .ENABLE(enable_b), .STALL(1'b0),
        .en_stage(en_b), .busy(busy_b), .ready(ready_b), .done(done_b), .ovf(ovf_b)
`ifdef H264_SEQ_BLKCNT_EN
        , .blk_cnt(blk_b)
`endif
    );

    // Advance one cycle, apply the inputs for the new cycle, let combinational outputs settle.
    task automatic drive(input logic rst, input logic en, input logic st);
        @(posedge CLK);
        #1;
        RESET  = rst;
        ENABLE = en;
        STALL  = st;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (en_a !== 4'h0 || busy_a !== 1'b0 || ready_a !== 1'b1 || done_a !== 1'b0 || ovf_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_a: en=%h busy=%b ready=%b done=%b ovf=%b, want en=0 busy=0 ready=1 done=0 ovf=0",
                     en_a, busy_a, ready_a, done_a, ovf_a);
        end
        n_vec++;
        if (en_b !== 6'h00 || busy_b !== 1'b0 || ready_b !== 1'b1 || done_b !== 1'b0 || ovf_b !== 1'b0) begin
            n_err++;
            $display("FAIL reset_b: en=%h busy=%b ready=%b done=%b ovf=%b, want en=0 busy=0 ready=1 done=0 ovf=0",
                     en_b, busy_b, ready_b, done_b, ovf_b);
        end
`ifdef H264_SEQ_BLKCNT_EN
        n_vec++;
        if (blk_a !== 16'd0) begin
            n_err++;
            $display("FAIL reset_blk_cnt: got %0d want 0", blk_a);
        end
`endif
    endtask

    task automatic test_single_block();
        int exp_en[8]   = '{1, 3, 5, 9, 0, 0, 0, 0};
        int exp_busy[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        int exp_done[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            n_vec++;
            if (en_a !== 4'(exp_en[i]) || busy_a !== 1'(exp_busy[i]) || done_a !== 1'(exp_done[i]) ||
                ready_a !== 1'b1 || ovf_a !== 1'b0) begin
                n_err++;
                $display("FAIL single c%0d: en=%h busy=%b done=%b ready=%b ovf=%b, want en=%h busy=%0d done=%0d ready=1 ovf=0",
                         i + 1, en_a, busy_a, done_a, ready_a, ovf_a, exp_en[i], exp_busy[i], exp_done[i]);
            end
        end
    endtask

    task automatic test_stall();
        int exp_en[10]   = '{1, 0, 0, 3, 5, 9, 0, 0, 0, 0};
        int exp_busy[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int exp_done[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, (i == 1 || i == 2));
            n_vec++;
            if (en_a !== 4'(exp_en[i]) || busy_a !== 1'(exp_busy[i]) || done_a !== 1'(exp_done[i])) begin
                n_err++;
                $display("FAIL stall c%0d: en=%h busy=%b done=%b, want en=%h busy=%0d done=%0d",
                         i + 1, en_a, busy_a, done_a, exp_en[i], exp_busy[i], exp_done[i]);
            end
        end
    endtask

    // With over=1 a third request at cycle 3 must be dropped; otherwise the queue fills once.
    task automatic test_queue(input logic over);
        int exp_en[15]    = '{1, 3, 5, 9, 0, 0, 0, 1, 3, 5, 9, 0, 0, 0, 0};
        int exp_done[15]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        int exp_ready[15] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        logic exp_ovf;
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, (i == 1) || (over && i == 2), 1'b0);
            exp_ovf = over && (i == 2);
            n_vec++;
            if (en_a !== 4'(exp_en[i]) || done_a !== 1'(exp_done[i]) || ready_a !== 1'(exp_ready[i]) ||
                ovf_a !== exp_ovf || busy_a !== (i != 14)) begin
                n_err++;
                $display("FAIL queue%0d c%0d: en=%h done=%b ready=%b ovf=%b busy=%b, want en=%h done=%0d ready=%0d ovf=%b busy=%b",
                         over, i + 1, en_a, done_a, ready_a, ovf_a, busy_a,
                         exp_en[i], exp_done[i], exp_ready[i], exp_ovf, (i != 14));
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (ready_a !== 1'b0 || en_a !== 4'h5) begin
            n_err++;
            $display("FAIL reset_mid_pre: ready=%b en=%h, want ready=0 en=5", ready_a, en_a);
        end
        drive(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (en_a !== 4'h0 || busy_a !== 1'b0 || ready_a !== 1'b1 || done_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_post: en=%h busy=%b ready=%b done=%b, want en=0 busy=0 ready=1 done=0",
                     en_a, busy_a, ready_a, done_a);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            n_vec++;
            if (en_a !== 4'h0 || busy_a !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_idle c%0d: en=%h busy=%b, want en=0 busy=0", i + 5, en_a, busy_a);
            end
        end
    endtask

    task automatic test_param_back_to_back();
        int exp_en[6] = '{'h01, 'h03, 'h04, 'h08, 'h10, 'h20};
`ifdef H264_SEQ_BLKCNT_EN
        n_vec++;
        if (blk_b !== 16'd0) begin
            n_err++;
            $display("FAIL param_blk_start: got %0d want 0", blk_b);
        end
`endif
        @(posedge CLK);
        #1;
        enable_b = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(posedge CLK);
            #2;
            n_vec++;
            if (en_b !== 6'(exp_en[i % 6]) || done_b !== (i % 6 == 5) || busy_b !== 1'b1) begin
                n_err++;
                $display("FAIL param c%0d: en=%h done=%b busy=%b, want en=%h done=%b busy=1",
                         i + 1, en_b, done_b, busy_b, exp_en[i % 6], (i % 6 == 5));
            end
        end
        @(posedge CLK);
        #1;
        enable_b = 1'b0;
        #1;
        n_vec++;
        if (en_b !== 6'h01 || busy_b !== 1'b1) begin
            n_err++;
            $display("FAIL param_c19: en=%h busy=%b, want en=01 busy=1", en_b, busy_b);
        end
`ifdef H264_SEQ_BLKCNT_EN
        n_vec++;
        if (blk_b !== 16'd3) begin
            n_err++;
            $display("FAIL param_blk_cnt: got %0d want 3", blk_b);
        end
`endif
        repeat (8) @(posedge CLK);
        #2;
        n_vec++;
        if (busy_b !== 1'b0 || en_b !== 6'h00) begin
            n_err++;
            $display("FAIL param_drain: busy=%b en=%h, want busy=0 en=00", busy_b, en_b);
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_stall();
        test_queue(1'b0);
        test_queue(1'b1);
        test_reset_mid();
        test_param_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
